// File: rtl/link_arq_ctrl_pkg.sv
// Shared types and default constants for the inter-board link ARQ sender.
package link_arq_ctrl_pkg;

    // Packet kinds carried over the serial link
    typedef enum logic [1:0] {
        PKT_DATA  = 2'd0,
        PKT_READY = 2'd1,
        PKT_LOST  = 2'd2,
        PKT_RSVD  = 2'd3
    } pkt_kind_t;

    // Sender state machine states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_FAIL     = 3'd4
    } arq_state_t;

    localparam int ARQ_TIMEOUT_TICKS = 200;
    localparam int ARQ_MAX_RETRIES   = 3;

    // Bits needed to hold the values 0..v, never less than one bit
    function automatic int min_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/link_arq_ctrl_sat_counter.sv
// Saturating up-counter used for the link-health statistics.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    // Count enabled events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/link_arq_ctrl.sv
// Stop-and-wait ARQ sender: one packet in flight, timeout-driven retransmit,
// link failure after the retry budget is spent, plus saturating statistics.
module link_arq_ctrl
    import link_arq_ctrl_pkg::*;
#(
    parameter int SEQ_BITS      = 1,
    parameter int TIMEOUT_TICKS = ARQ_TIMEOUT_TICKS,
    parameter int MAX_RETRIES   = ARQ_MAX_RETRIES,
    parameter int CNT_BITS      = 4
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                tick,
    input  logic                req_valid,
    input  pkt_kind_t           req_kind,
    output logic                req_ready,
    output logic                tx_start,
    output pkt_kind_t           tx_kind,
    output logic [SEQ_BITS-1:0] tx_seq,
    input  logic                tx_done,
    input  logic                ack_valid,
    input  logic [SEQ_BITS-1:0] ack_seq,
    input  logic                clear_fail,
    output logic                link_fail,
    output logic                busy,
    output logic [CNT_BITS-1:0] sent_cnt,
    output logic [CNT_BITS-1:0] retx_cnt,
    output logic [CNT_BITS-1:0] acked_cnt
);

    localparam int TMR_W = min_width(TIMEOUT_TICKS);
    localparam int RTY_W = min_width(MAX_RETRIES);

    // Timeout fires on the tick that would bring the timer to TIMEOUT_TICKS
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    arq_state_t       state;
    logic [TMR_W-1:0] timer;
    logic [RTY_W-1:0] retries;

    logic accept;
    logic ack_match;
    logic timeout;
    logic retx_go;

    // A matching ACK always takes priority over a coincident timeout
    assign accept    = req_valid & req_ready;
    assign ack_match = (state == ST_WAIT_ACK) & ack_valid & (ack_seq == tx_seq);
    assign timeout   = (state == ST_WAIT_ACK) & tick & (timer == TMR_LAST) & ~ack_match;
    assign retx_go   = timeout & (retries < RTY_MAX);

    // Sender FSM with registered outputs, retry bookkeeping and ACK timer
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            tx_start  <= 1'b0;
            tx_kind   <= PKT_DATA;
            tx_seq    <= '0;
            link_fail <= 1'b0;
            busy      <= 1'b0;
            timer     <= '0;
            retries   <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_kind   <= req_kind;
                        retries   <= '0;
                        tx_start  <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    // Any ACK arriving while still shifting out is ignored
                    if (tx_done) begin
                        timer <= '0;
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_match) begin
                        tx_seq    <= tx_seq + 1'b1;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (retx_go) begin
                        retries  <= retries + 1'b1;
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end else if (timeout) begin
                        link_fail <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_FAIL;
                    end else if (tick) begin
                        // Stale ACKs fall through here and leave the timer running
                        timer <= timer + 1'b1;
                    end
                end
                ST_FAIL: begin
                    // Sequence number and statistics survive the failure
                    if (clear_fail) begin
                        link_fail <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    link_fail <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_BITS)) u_sent_cnt (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (accept),
        .clr   (1'b0),
        .cnt   (sent_cnt)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_retx_cnt (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (retx_go),
        .clr   (1'b0),
        .cnt   (retx_cnt)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_acked_cnt (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (ack_match),
        .clr   (1'b0),
        .cnt   (acked_cnt)
    );

endmodule

// File: tb/tb_link_arq_ctrl.sv
// Directed bench for link_arq_ctrl: a default-parameter instance for the basic
// handshake and a short-timeout, 2-bit-sequence instance for everything else.
module tb_link_arq_ctrl;
    import link_arq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       tick;
    logic       req_valid;
    pkt_kind_t  req_kind;
    logic       tx_done;
    logic       ack_valid;
    logic [1:0] ack_seq;
    logic       clear_fail;

    logic       a_req_ready, a_tx_start, a_link_fail, a_busy;
    pkt_kind_t  a_tx_kind;
    logic [0:0] a_tx_seq;
    logic [3:0] a_sent, a_retx, a_acked;

    logic       b_req_ready, b_tx_start, b_link_fail, b_busy;
    pkt_kind_t  b_tx_kind;
    logic [1:0] b_tx_seq;
    logic [3:0] b_sent, b_retx, b_acked;

    int n_checks = 0;
    int n_errors = 0;
    int b_starts = 0;
    logic starts_clr = 1'b0;

    always #10 clk = ~clk;

    link_arq_ctrl #(
        .SEQ_BITS(1), .TIMEOUT_TICKS(200), .MAX_RETRIES(3), .CNT_BITS(4)
    ) dut_a (
        .clk(clk), .rst_l(rst_l), .tick(tick),
        .req_valid(req_valid), .req_kind(req_kind), .req_ready(a_req_ready),
        .tx_start(a_tx_start), .tx_kind(a_tx_kind), .tx_seq(a_tx_seq),
        .tx_done(tx_done), .ack_valid(ack_valid), .ack_seq(ack_seq[0:0]),
        .clear_fail(clear_fail), .link_fail(a_link_fail), .busy(a_busy),
        .sent_cnt(a_sent), .retx_cnt(a_retx), .acked_cnt(a_acked)
    );

    link_arq_ctrl #(
        .SEQ_BITS(2), .TIMEOUT_TICKS(4), .MAX_RETRIES(3), .CNT_BITS(4)
    ) dut_b (
        .clk(clk), .rst_l(rst_l), .tick(tick),
        .req_valid(req_valid), .req_kind(req_kind), .req_ready(b_req_ready),
        .tx_start(b_tx_start), .tx_kind(b_tx_kind), .tx_seq(b_tx_seq),
        .tx_done(tx_done), .ack_valid(ack_valid), .ack_seq(ack_seq),
        .clear_fail(clear_fail), .link_fail(b_link_fail), .busy(b_busy),
        .sent_cnt(b_sent), .retx_cnt(b_retx), .acked_cnt(b_acked)
    );

    // Count tx_start pulses of the short-timeout instance
    always @(posedge clk) begin
        if (starts_clr) b_starts <= 0;
        else if (b_tx_start) b_starts <= b_starts + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_req(input pkt_kind_t k);
        req_valid = 1'b1;
        req_kind  = k;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic pulse_ack(input logic [1:0] s);
        ack_valid = 1'b1;
        ack_seq   = s;
        @(negedge clk);
        ack_valid = 1'b0;
    endtask

    task automatic clr_starts();
        starts_clr = 1'b1;
        @(negedge clk);
        starts_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_l = 1'b0; tick = 1'b0; req_valid = 1'b0; req_kind = PKT_DATA;
        tx_done = 1'b0; ack_valid = 1'b0; ack_seq = 2'd0; clear_fail = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_a_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_a_tx_start",  32'(a_tx_start),  32'd0);
        check("rst_b_busy",      32'(b_busy),      32'd0);
        check("rst_b_link_fail", 32'(b_link_fail), 32'd0);
        check("rst_b_tx_seq",    32'(b_tx_seq),    32'd0);
        check("rst_b_sent",      32'(b_sent),      32'd0);
        rst_l = 1'b1;
        @(negedge clk);

        // Basic ACK on the default instance
        pulse_req(PKT_DATA);
        check("basic_tx_start",  32'(a_tx_start),  32'd1);
        check("basic_req_ready", 32'(a_req_ready), 32'd0);
        check("basic_busy",      32'(a_busy),      32'd1);
        check("basic_kind",      32'(a_tx_kind),   32'(PKT_DATA));
        @(negedge clk);
        check("basic_start_1clk", 32'(a_tx_start), 32'd0);
        pulse_done();
        ticks(5);
        pulse_ack(2'd0);
        check("basic_tx_seq",    32'(a_tx_seq),    32'd1);
        check("basic_acked",     32'(a_acked),     32'd1);
        check("basic_sent",      32'(a_sent),      32'd1);
        check("basic_retx",      32'(a_retx),      32'd0);
        check("basic_req_ready2", 32'(a_req_ready), 32'd1);
        check("basic_busy2",     32'(a_busy),      32'd0);

        // Retry then success (timeout 4, retries 3)
        do_reset();
        clr_starts();
        pulse_req(PKT_READY);
        check("retry_start1", 32'(b_tx_start), 32'd1);
        @(negedge clk);
        pulse_done();
        ticks(3);
        check("retry_no_early", 32'(b_starts), 32'd1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("retry_start2", 32'(b_tx_start), 32'd1);
        check("retry_seq",    32'(b_tx_seq),   32'd0);
        check("retry_kind",   32'(b_tx_kind),  32'(PKT_READY));
        check("retry_retx",   32'(b_retx),     32'd1);
        @(negedge clk);
        pulse_done();
        pulse_ack(2'd0);
        check("retry_acked",  32'(b_acked),     32'd1);
        check("retry_ready",  32'(b_req_ready), 32'd1);
        check("retry_seq2",   32'(b_tx_seq),    32'd1);
        check("retry_starts", 32'(b_starts),    32'd2);

        // Failure and clear
        do_reset();
        clr_starts();
        pulse_req(PKT_DATA);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pulse_done();
            ticks(4);
        end
        check("fail_link_fail", 32'(b_link_fail), 32'd1);
        check("fail_busy",      32'(b_busy),      32'd0);
        check("fail_req_ready", 32'(b_req_ready), 32'd0);
        check("fail_retx",      32'(b_retx),      32'd3);
        check("fail_starts",    32'(b_starts),    32'd4);
        pulse_req(PKT_DATA);
        @(negedge clk);
        check("fail_req_ignored", 32'(b_sent),      32'd1);
        check("fail_held",        32'(b_link_fail), 32'd1);
        clear_fail = 1'b1;
        @(negedge clk);
        clear_fail = 1'b0;
        check("clear_link_fail", 32'(b_link_fail), 32'd0);
        check("clear_req_ready", 32'(b_req_ready), 32'd1);
        check("clear_tx_seq",    32'(b_tx_seq),    32'd0);
        check("clear_retx_kept", 32'(b_retx),      32'd3);

        // Stale ACK then matching ACK racing the final tick
        clr_starts();
        pulse_req(PKT_LOST);
        @(negedge clk);
        pulse_done();
        ticks(2);
        pulse_ack(2'd1);
        check("stale_busy",  32'(b_busy),  32'd1);
        check("stale_acked", 32'(b_acked), 32'd0);
        ticks(2);
        check("stale_retx",   32'(b_retx),   32'd4);
        check("stale_starts", 32'(b_starts), 32'd2);
        pulse_done();
        ticks(3);
        tick = 1'b1;
        ack_valid = 1'b1;
        ack_seq = 2'd0;
        @(negedge clk);
        tick = 1'b0;
        ack_valid = 1'b0;
        check("race_tx_start", 32'(b_tx_start),  32'd0);
        check("race_acked",    32'(b_acked),     32'd1);
        check("race_retx",     32'(b_retx),      32'd4);
        check("race_ready",    32'(b_req_ready), 32'd1);
        check("race_seq",      32'(b_tx_seq),    32'd1);
        repeat (3) @(negedge clk);
        check("race_starts", 32'(b_starts), 32'd2);

        // Sequence wrap and counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap_seq_%0d", i), 32'(b_tx_seq), 32'(i % 4));
            pulse_req(PKT_DATA);
            @(negedge clk);
            pulse_done();
            pulse_ack(2'(i % 4));
        end
        check("sat_sent",  32'(b_sent),   32'd15);
        check("sat_acked", 32'(b_acked),  32'd15);
        check("sat_retx",  32'(b_retx),   32'd0);
        check("wrap_end",  32'(b_tx_seq), 32'd0);

        // Asynchronous reset while waiting for an ACK
        pulse_req(PKT_DATA);
        @(negedge clk);
        pulse_done();
        ticks(2);
        check("mid_busy", 32'(b_busy), 32'd1);
        clr_starts();
        rst_l = 1'b0;
        #1;
        check("async_busy",      32'(b_busy),      32'd0);
        check("async_req_ready", 32'(b_req_ready), 32'd1);
        check("async_tx_start",  32'(b_tx_start),  32'd0);
        check("async_sent",      32'(b_sent),      32'd0);
        check("async_tx_seq",    32'(b_tx_seq),    32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        ticks(5);
        check("post_rst_starts", 32'(b_starts),    32'd0);
        check("post_rst_ready",  32'(b_req_ready), 32'd1);
        check("post_rst_busy",   32'(b_busy),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
